vertex_transform: RTL and testbench

Fetches packed (x, y, z) vertices from the GPU vertex memory and multiplies each by the 4x4 fixed-point transform matrix, with implied w = 1.0. Emits transformed vertices on a valid/ready stream to the downstream rasteriser stage. Sits inside GPU_top directly behind the vertex memory read port. Driven by the same `start`, `vertex_count` and `transform_matrix` inputs that GPU_top exposes.

---
 rtl/vertex_transform.sv | 222 ++++++++++++++++++++++
 tb/tb_vertex_transform.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_transform.sv
// vertex_transform: fetches packed (x,y,z) words, applies a 4x4 Q(M).(N)
// matrix with implied w = 1.0 and streams saturated results downstream.
module vertex_transform #(
   parameter int M                = 11,
   parameter int N                = 7,
   parameter int VERTEX_MEM_DEPTH = 16384,
   parameter int AW               = $clog2(VERTEX_MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [31:0]           vertex_count,
   input  logic signed [M+N-1:0] transform_matrix [16],
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [AW-1:0]         mem_rd_addr,
   input  logic signed [M+N-1:0] mem_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [M+N-1:0] out_x,
   output logic signed [M+N-1:0] out_y,
   output logic signed [M+N-1:0] out_z,
   output logic [AW-1:0]         out_index
);

   localparam int W   = M + N;
   localparam int AC  = 2 * W + 2;
   localparam int AW1 = AW + 1;

   localparam logic signed [AC-1:0] SAT_MAX =
      {{(AC-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [AC-1:0] SAT_MIN =
      {{(AC-W+1){1'b1}}, {(W-1){1'b0}}};

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_COMPUTE = 3'd3;
   localparam logic [2:0] S_EMIT    = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]          state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                skip_q, skip_d;
   logic [AW-1:0]       base_q, base_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [AW-1:0]       nverts_q, nverts_d;
   logic                rd_en_q, rd_en_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic signed [W-1:0] ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
   logic [AW-1:0]       oidx_q, oidx_d;
   logic                valid_q, valid_d;
   logic signed [W-1:0] mat_q [16];
   logic signed [W-1:0] mat_d [16];

   logic [AW1-1:0]      vc_clamp;
   logic [AW-1:0]       nv_calc;
   logic signed [AC-1:0] acc [3];
   logic signed [AC-1:0] shf [3];
   logic signed [W-1:0]  res [3];

   always_comb begin
      vc_clamp = (vertex_count > 32'(VERTEX_MEM_DEPTH)) ?
                 AW1'(VERTEX_MEM_DEPTH) : vertex_count[AW:0];
      nv_calc  = AW'(vc_clamp / AW1'(3));
   end

   // Full-width MAC, floor shift, then clamp to the output range.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         acc[r] = AC'(mat_q[r*4])   * AC'(x_q)
                + AC'(mat_q[r*4+1]) * AC'(y_q)
                + AC'(mat_q[r*4+2]) * AC'(z_q)
                + (AC'(mat_q[r*4+3]) <<< N);
         shf[r] = acc[r] >>> N;
         if (shf[r] > SAT_MAX)
            res[r] = SAT_MAX[W-1:0];
         else if (shf[r] < SAT_MIN)
            res[r] = SAT_MIN[W-1:0];
         else
            res[r] = shf[r][W-1:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      skip_d   = skip_q;
      base_d   = base_q;
      idx_d    = idx_q;
      nverts_d = nverts_q;
      rd_en_d  = 1'b0;
      addr_d   = addr_q;
      x_d      = x_q;
      y_d      = y_q;
      z_d      = z_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      oz_d     = oz_q;
      oidx_d   = oidx_q;
      valid_d  = valid_q;
      mat_d    = mat_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mat_d    = transform_matrix;
               nverts_d = nv_calc;
               base_d   = '0;
               idx_d    = '0;
               if (nv_calc == '0) begin
                  state_d = S_DONE;
                  skip_d  = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  cnt_d   = 2'd0;
                  rd_en_d = 1'b1;
                  addr_d  = '0;
               end
            end
         end
         S_FETCH: begin
            // Data lags the strobe by one cycle.
            if (cnt_q == 2'd1) x_d = mem_rd_data;
            if (cnt_q == 2'd2) y_d = mem_rd_data;
            if (cnt_q != 2'd2) begin
               rd_en_d = 1'b1;
               addr_d  = addr_q + AW'(1);
               cnt_d   = cnt_q + 2'd1;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            z_d     = mem_rd_data;
            state_d = S_COMPUTE;
         end
         S_COMPUTE: begin
            ox_d    = res[0];
            oy_d    = res[1];
            oz_d    = res[2];
            oidx_d  = idx_q;
            valid_d = 1'b1;
            state_d = S_EMIT;
         end
         S_EMIT: begin
            if (out_ready) begin
               valid_d = 1'b0;
               if (idx_q == nverts_q - AW'(1)) begin
                  state_d = S_DONE;
                  skip_d  = 1'b0;
               end else begin
                  base_d  = base_q + AW'(3);
                  idx_d   = idx_q + AW'(1);
                  addr_d  = base_q + AW'(3);
                  rd_en_d = 1'b1;
                  cnt_d   = 2'd0;
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE: begin
            // Empty jobs linger one cycle so done lands after E1.
            if (skip_q) skip_d = 1'b0;
            else        state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         skip_q   <= 1'b0;
         base_q   <= '0;
         idx_q    <= '0;
         nverts_q <= '0;
         rd_en_q  <= 1'b0;
         addr_q   <= '0;
         x_q      <= '0;
         y_q      <= '0;
         z_q      <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
         oz_q     <= '0;
         oidx_q   <= '0;
         valid_q  <= 1'b0;
         for (int i = 0; i < 16; i++) mat_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         skip_q   <= skip_d;
         base_q   <= base_d;
         idx_q    <= idx_d;
         nverts_q <= nverts_d;
         rd_en_q  <= rd_en_d;
         addr_q   <= addr_d;
         x_q      <= x_d;
         y_q      <= y_d;
         z_q      <= z_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         oz_q     <= oz_d;
         oidx_q   <= oidx_d;
         valid_q  <= valid_d;
         for (int i = 0; i < 16; i++) mat_q[i] <= mat_d[i];
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE) && !skip_q;
   assign mem_rd_en   = rd_en_q;
   assign mem_rd_addr = addr_q;
   assign out_valid   = valid_q;
   assign out_x       = ox_q;
   assign out_y       = oy_q;
   assign out_z       = oz_q;
   assign out_index   = oidx_q;

endmodule

// File: tb/tb_vertex_transform.sv
// tb_vertex_transform: directed vectors plus hand-built sequences for
// latency, backpressure, count clamping, interference and reset.
module tb_vertex_transform;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                start = 1'b0;
   logic [31:0]         vertex_count = '0;
   logic signed [17:0]  transform_matrix [16];
   logic                busy, done, mem_rd_en, out_valid;
   logic                out_ready = 1'b1;
   logic [13:0]         mem_rd_addr, out_index;
   logic signed [17:0]  mem_rd_data = '0;
   logic signed [17:0]  out_x, out_y, out_z;

   logic signed [17:0]  mem [16384];

   vertex_transform dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .vertex_count     (vertex_count),
      .transform_matrix (transform_matrix),
      .busy             (busy),
      .done             (done),
      .mem_rd_en        (mem_rd_en),
      .mem_rd_addr      (mem_rd_addr),
      .mem_rd_data      (mem_rd_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_x            (out_x),
      .out_y            (out_y),
      .out_z            (out_z),
      .out_index        (out_index)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   int n_cmp = 0;
   int n_bad = 0;

   logic signed [17:0] qx [$];
   logic signed [17:0] qy [$];
   logic signed [17:0] qz [$];
   int qi [$];
   int rd_cnt, rd_first_addr, first_valid_j, last_hs_j;
   int done_j, done_cnt, stall_bad;
   bit busy_at_done, busy_fall, timed_out;

   task automatic chk(input string name, input longint act,
                      input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_example;
      int ex [16];
      ex = '{83, -48, -83, 0, 34, 118, -34, 0,
             90, 0, 90, 0, 0, 0, 0, 128};
      for (int i = 0; i < 16; i++) transform_matrix[i] = 18'(ex[i]);
      mem[0] = 18'sd128; mem[1] = 18'sd0;   mem[2] = 18'sd0;
      mem[3] = 18'sd128; mem[4] = 18'sd128; mem[5] = 18'sd128;
   endtask

   task automatic run(input logic [31:0] vc, input int stall,
                      input bit poke, input int budget);
      int j;
      int stall_left;
      bit snap;
      logic signed [17:0] sx, sy, sz;
      logic [13:0] si;
      qx.delete(); qy.delete(); qz.delete(); qi.delete();
      rd_cnt = 0; rd_first_addr = -1; first_valid_j = -1;
      last_hs_j = -1; done_j = -1; done_cnt = 0; stall_bad = 0;
      busy_at_done = 0; busy_fall = 1; timed_out = 0;
      stall_left = stall; snap = 0;
      sx = '0; sy = '0; sz = '0; si = '0;
      vertex_count = vc;
      out_ready = 1'b1;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      j = 0;
      forever begin
         if (mem_rd_en) begin
            if (rd_cnt == 0) rd_first_addr = int'(mem_rd_addr);
            rd_cnt++;
         end
         if (out_valid && first_valid_j < 0) first_valid_j = j;
         if (done) begin
            done_cnt++;
            if (done_j < 0) begin
               done_j = j;
               busy_at_done = busy;
            end
         end
         if (done_j >= 0 && j == done_j + 1) busy_fall = busy;
         if (out_valid && stall_left > 0) begin
            if (!snap) begin
               snap = 1; sx = out_x; sy = out_y; sz = out_z; si = out_index;
            end else if (out_x != sx || out_y != sy || out_z != sz ||
                         out_index != si) stall_bad++;
            if (mem_rd_en) stall_bad++;
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            qx.push_back(out_x); qy.push_back(out_y); qz.push_back(out_z);
            qi.push_back(int'(out_index));
            last_hs_j = j;
         end
         start = poke && (j == 3 || done);
         if (poke && j == 3)
            for (int i = 0; i < 16; i++) transform_matrix[i] = 18'sd7;
         if (done_j >= 0 && j >= done_j + 6) break;
         if (j >= budget) begin
            timed_out = 1;
            break;
         end
         j++;
         @(negedge clk);
      end
      start = 1'b0;
      out_ready = 1'b1;
      chk("timeout", timed_out, 0);
   endtask

   typedef struct {
      string nm;
      int m0, m1, m2, m3;
      int x, y, z;
      int ex;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int k;
      vecs[0] = '{"unity",     128, 0, 0, 0,           5, 6, 7, 5};
      vecs[1] = '{"floor_neg", 64, 0, 0, 0,           -1, 0, 0, -1};
      vecs[2] = '{"sat_pos",   131071, 0, 0, 131071,  131071, 0, 0, 131071};
      vecs[3] = '{"sat_neg",   131071, 0, 0, -131071, -131071, 0, 0, -131072};
      vecs[4] = '{"transl",    0, 0, 0, 128,           0, 0, 0, 128};
      vecs[5] = '{"sum_trunc", 64, 64, 64, 0,          1, 1, 1, 1};
      vecs[6] = '{"floor_m64", -64, 0, 0, 0,           1, 0, 0, -1};
      vecs[7] = '{"mix_off",   128, 128, 0, -64,       100, -50, 0, -14};
      vecs[8] = '{"z_neg",     0, 0, 256, 1,           0, 0, -3, -5};

      for (int i = 0; i < 16384; i++) mem[i] = '0;
      for (int i = 0; i < 16; i++) transform_matrix[i] = '0;

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_addr", mem_rd_addr, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_x", out_x, 0);
      chk("rst_y", out_y, 0);
      chk("rst_z", out_z, 0);
      chk("rst_idx", out_index, 0);
      @(negedge clk); reset = 1'b1;

      for (int v = 0; v < 9; v++) begin
         for (int i = 0; i < 16; i++) transform_matrix[i] = '0;
         transform_matrix[0] = 18'(vecs[v].m0);
         transform_matrix[1] = 18'(vecs[v].m1);
         transform_matrix[2] = 18'(vecs[v].m2);
         transform_matrix[3] = 18'(vecs[v].m3);
         mem[0] = 18'(vecs[v].x);
         mem[1] = 18'(vecs[v].y);
         mem[2] = 18'(vecs[v].z);
         run(32'd3, 0, 0, 200);
         chk({vecs[v].nm, "_n"}, qx.size(), 1);
         if (qx.size() == 1) begin
            chk({vecs[v].nm, "_x"}, qx[0], vecs[v].ex);
            chk({vecs[v].nm, "_y"}, qy[0], 0);
         end
      end

      set_example();
      run(32'd6, 0, 0, 200);
      chk("ex_n", qx.size(), 2);
      if (qx.size() == 2) begin
         chk("ex_v0x", qx[0], 83);
         chk("ex_v0y", qy[0], 34);
         chk("ex_v0z", qz[0], 90);
         chk("ex_v1x", qx[1], -48);
         chk("ex_v1y", qy[1], 118);
         chk("ex_v1z", qz[1], 180);
         chk("ex_i0", qi[0], 0);
         chk("ex_i1", qi[1], 1);
      end
      chk("ex_lat", first_valid_j, 5);
      chk("ex_done_j", done_j, 12);
      chk("ex_done_after_hs", done_j, last_hs_j + 1);
      chk("ex_busy_at_done", busy_at_done, 1);
      chk("ex_busy_fall", busy_fall, 0);
      chk("ex_rd_cnt", rd_cnt, 6);
      chk("ex_rd_addr0", rd_first_addr, 0);
      chk("ex_done_cnt", done_cnt, 1);

      run(32'd3, 10, 0, 200);
      chk("bp_stable", stall_bad, 0);
      chk("bp_n", qx.size(), 1);
      if (qx.size() == 1) chk("bp_x", qx[0], 83);
      chk("bp_rd_cnt", rd_cnt, 3);
      chk("bp_lat", last_hs_j, 15);

      run(32'd2, 0, 0, 50);
      chk("vc2_rd", rd_cnt, 0);
      chk("vc2_done_j", done_j, 1);
      chk("vc2_n", qx.size(), 0);
      chk("vc2_busy_fall", busy_fall, 0);

      run(32'd7, 0, 0, 200);
      chk("vc7_n", qx.size(), 2);
      chk("vc7_rd", rd_cnt, 6);

      run(32'hFFFF_FFFF, 0, 0, 33000);
      chk("big_n", qi.size(), 5461);
      if (qi.size() > 0) chk("big_last", qi[$], 5460);
      chk("big_rd", rd_cnt, 16383);
      chk("big_done_cnt", done_cnt, 1);

      set_example();
      run(32'd6, 0, 1, 200);
      chk("int_n", qx.size(), 2);
      if (qx.size() == 2) begin
         chk("int_v0x", qx[0], 83);
         chk("int_v1y", qy[1], 118);
         chk("int_v1z", qz[1], 180);
      end
      chk("int_done_cnt", done_cnt, 1);
      chk("int_busy_fall", busy_fall, 0);

      set_example();
      vertex_count = 32'd6;
      out_ready = 1'b1;
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      k = 0;
      while (!(out_valid && out_index == 14'd1) && k < 100) begin
         @(negedge clk);
         k++;
      end
      out_ready = 1'b0;
      chk("rm_reach", k < 100, 1);
      #2 reset = 1'b0;
      #1;
      chk("rm_valid", out_valid, 0);
      chk("rm_x", out_x, 0);
      chk("rm_y", out_y, 0);
      chk("rm_idx", out_index, 0);
      chk("rm_busy", busy, 0);
      chk("rm_rd_en", mem_rd_en, 0);
      @(negedge clk); reset = 1'b1;
      out_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done || busy) k++;
      end
      chk("rm_quiet", k, 0);
      run(32'd6, 0, 0, 200);
      chk("rm_again_addr0", rd_first_addr, 0);
      chk("rm_again_n", qx.size(), 2);
      if (qx.size() == 2) chk("rm_again_v1x", qx[1], -48);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
